// File: rtl/hssl_probe_capture.sv
// Multi-channel asynchronous probe capture: per-bit synchroniser, per-channel
// stability filter, coherent registered outputs with change pulse/sticky/count.
module hssl_probe_capture #(
    parameter int NUM_CH      = 13,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] probe_in,
    input  logic                     freeze,
    input  logic                     clear,
    output logic [NUM_CH*DATA_W-1:0] probe_out,
    output logic [NUM_CH-1:0]        probe_chg,
    output logic [NUM_CH-1:0]        probe_sticky,
    output logic [NUM_CH*CNT_W-1:0]  probe_cnt,
    output logic [NUM_CH-1:0]        probe_stable
);

    localparam int RUN_W = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [NUM_CH*DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH*DATA_W-1:0] s_all;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= probe_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_all = sync_q[SYNC_STAGES-1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] cand;
        logic [DATA_W-1:0] out_q;
        logic [RUN_W-1:0]  run;
        logic [CNT_W-1:0]  cnt;
        logic              chg;
        logic              sticky;
        logic              stable;
        logic              accept;
        logic              update;

        assign s      = s_all[c*DATA_W +: DATA_W];
        assign accept = (run == RUN_MAX) && (s == cand) && !freeze;
        assign update = accept && (cand != out_q);

        // Any difference restarts the run, so a torn bus never qualifies.
        always_ff @(posedge clk) begin
            if (reset) begin
                cand <= '0;
                run  <= '0;
            end else if (s != cand) begin
                cand <= s;
                run  <= RUN_W'(1);
            end else if (run < RUN_MAX) begin
                run <= run + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                out_q  <= '0;
                chg    <= 1'b0;
                stable <= 1'b0;
            end else begin
                chg <= update;
                if (update) begin
                    out_q <= cand;
                end
                if (accept) begin
                    stable <= 1'b1;
                end
            end
        end

        // A change coinciding with clear survives as a single counted event.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt    <= '0;
                sticky <= 1'b0;
            end else if (clear) begin
                cnt    <= update ? CNT_W'(1) : '0;
                sticky <= update;
            end else if (update) begin
                sticky <= 1'b1;
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign probe_out[c*DATA_W +: DATA_W] = out_q;
        assign probe_cnt[c*CNT_W +: CNT_W]   = cnt;
        assign probe_chg[c]                  = chg;
        assign probe_sticky[c]               = sticky;
        assign probe_stable[c]               = stable;
    end

endmodule

// File: tb/tb_hssl_probe_capture.sv
// Scoreboard bench for hssl_probe_capture: expected change events are queued
// at stimulus time and matched against probe_chg pulses.
module tb_hssl_probe_capture;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SS     = 2;
    localparam int SC     = 4;
    localparam int CNT_W  = 2;
    localparam int LAT    = SS + SC + 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     freeze;
    logic                     clear;
    logic [NUM_CH*DATA_W-1:0] probe_in;
    logic [NUM_CH*DATA_W-1:0] probe_out;
    logic [NUM_CH-1:0]        probe_chg;
    logic [NUM_CH-1:0]        probe_sticky;
    logic [NUM_CH*CNT_W-1:0]  probe_cnt;
    logic [NUM_CH-1:0]        probe_stable;

    hssl_probe_capture #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(SS),
        .STABLE_CNT(SC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .probe_in(probe_in),
        .freeze(freeze), .clear(clear), .probe_out(probe_out),
        .probe_chg(probe_chg), .probe_sticky(probe_sticky),
        .probe_cnt(probe_cnt), .probe_stable(probe_stable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         ch;
        logic [7:0] val;
        logic [1:0] cnt;
        logic       sticky;
        int         due;
    } ev_t;

    ev_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_cnt [NUM_CH];
    logic       exp_sticky [NUM_CH];

    function automatic logic [7:0] out_ch(int c);
        return probe_out[c*DATA_W +: DATA_W];
    endfunction

    function automatic logic [1:0] cnt_ch(int c);
        return probe_cnt[c*CNT_W +: CNT_W];
    endfunction

    // Every pulse must match the oldest queued event exactly.
    always @(negedge clk) begin
        ev_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            if (probe_chg[c] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_chg ch%0d cyc %0d out=%h, required no pulse",
                             c, cyc, out_ch(c));
                end else begin
                    e = sb.pop_front();
                    if (e.ch != c || out_ch(c) !== e.val || cnt_ch(c) !== e.cnt ||
                        probe_sticky[c] !== e.sticky || cyc != e.due) begin
                        errors++;
                        $display("FAIL chg_event got ch%0d out=%h cnt=%0d sticky=%b cyc=%0d, required ch%0d out=%h cnt=%0d sticky=%b cyc=%0d",
                                 c, out_ch(c), cnt_ch(c), probe_sticky[c], cyc,
                                 e.ch, e.val, e.cnt, e.sticky, e.due);
                    end
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ch(int c, logic [7:0] v);
        probe_in[c*DATA_W +: DATA_W] = v;
    endtask

    task automatic push_event(int c, logic [7:0] v, int due);
        ev_t e;
        exp_cnt[c]    = (exp_cnt[c] == 2'd3) ? 2'd3 : exp_cnt[c] + 2'd1;
        exp_sticky[c] = 1'b1;
        e.ch     = c;
        e.val    = v;
        e.cnt    = exp_cnt[c];
        e.sticky = exp_sticky[c];
        e.due    = due;
        sb.push_back(e);
    endtask

    task automatic zero_model();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_cnt[c]    = 2'd0;
            exp_sticky[c] = 1'b0;
        end
    endtask

    task automatic check_all_zero(string tag);
        checks++;
        if (probe_out !== '0 || probe_chg !== '0 || probe_sticky !== '0 ||
            probe_cnt !== '0 || probe_stable !== '0) begin
            errors++;
            $display("FAIL %s got out=%h chg=%b sticky=%b cnt=%h stable=%b, required all 0",
                     tag, probe_out, probe_chg, probe_sticky, probe_cnt, probe_stable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; freeze = 1'b0; clear = 1'b0; probe_in = '0;
        zero_model();
        tick(2);
        check_all_zero("reset_state");
        reset = 1'b0;
        tick(3);
        checks++;
        if (probe_stable !== 4'h0) begin
            errors++;
            $display("FAIL stable_early got %b, required 0000", probe_stable);
        end
        tick(3);
        checks++;
        if (probe_stable !== 4'hF || probe_out !== '0) begin
            errors++;
            $display("FAIL stable_rise got stable=%b out=%h, required 1111 and 0",
                     probe_stable, probe_out);
        end
    endtask

    task automatic test_latency();
        set_ch(0, 8'hA5);
        push_event(0, 8'hA5, cyc + LAT);
        tick(LAT - 1);
        checks++;
        if (out_ch(0) !== 8'h00) begin
            errors++;
            $display("FAIL latency_early got %h, required 00", out_ch(0));
        end
        tick(1);
        checks++;
        if (out_ch(0) !== 8'hA5 || probe_chg[0] !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge got out=%h chg=%b, required a5 1",
                     out_ch(0), probe_chg[0]);
        end
        tick(1);
        checks++;
        if (probe_chg[0] !== 1'b0) begin
            errors++;
            $display("FAIL chg_width got %b, required 0", probe_chg[0]);
        end
        tick(4);
    endtask

    task automatic test_glitch();
        set_ch(0, 8'h00);
        push_event(0, 8'h00, cyc + LAT);
        tick(10);
        for (int i = 0; i < 10; i++) begin
            set_ch(0, (i % 2 == 0) ? 8'hFF : 8'h00);
            tick(2);
            checks++;
            if (out_ch(0) !== 8'h00) begin
                errors++;
                $display("FAIL glitch_hold step %0d got %h, required 00", i, out_ch(0));
            end
        end
        set_ch(0, 8'hFF);
        push_event(0, 8'hFF, cyc + LAT);
        tick(LAT - 1);
        checks++;
        if (out_ch(0) !== 8'h00) begin
            errors++;
            $display("FAIL glitch_settle_early got %h, required 00", out_ch(0));
        end
        tick(1);
        checks++;
        if (out_ch(0) !== 8'hFF) begin
            errors++;
            $display("FAIL glitch_settle got %h, required ff", out_ch(0));
        end
        tick(3);
    endtask

    task automatic test_counter();
        for (int k = 1; k <= 5; k++) begin
            set_ch(1, 8'(k));
            push_event(1, 8'(k), cyc + LAT);
            tick(10);
        end
        checks++;
        if (cnt_ch(1) !== 2'd3 || probe_sticky[1] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_saturate got cnt=%0d sticky=%b, required 3 1",
                     cnt_ch(1), probe_sticky[1]);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        zero_model();
        checks++;
        if (probe_cnt !== '0 || probe_sticky !== '0) begin
            errors++;
            $display("FAIL clear_all got cnt=%h sticky=%b, required 0",
                     probe_cnt, probe_sticky);
        end
        tick(2);
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            set_ch(2, 8'(v));
            tick(10);
            checks++;
            if (out_ch(2) !== 8'h00 || cnt_ch(2) !== 2'd0) begin
                errors++;
                $display("FAIL freeze_hold step %0d got out=%h cnt=%0d, required 00 0",
                         v, out_ch(2), cnt_ch(2));
            end
        end
        freeze = 1'b0;
        push_event(2, 8'h03, cyc + 1);
        tick(1);
        checks++;
        if (out_ch(2) !== 8'h03 || cnt_ch(2) !== 2'd1) begin
            errors++;
            $display("FAIL freeze_release got out=%h cnt=%0d, required 03 1",
                     out_ch(2), cnt_ch(2));
        end
        tick(3);
        checks++;
        if (cnt_ch(2) !== 2'd1) begin
            errors++;
            $display("FAIL freeze_single got cnt=%0d, required 1", cnt_ch(2));
        end
    endtask

    task automatic test_clear_coincident();
        set_ch(0, 8'h3C);
        tick(LAT - 1);
        clear = 1'b1;
        zero_model();
        push_event(0, 8'h3C, cyc + 1);
        tick(1);
        clear = 1'b0;
        checks++;
        if (probe_cnt !== 8'b0000_0001 || probe_sticky !== 4'b0001) begin
            errors++;
            $display("FAIL clear_coincident got cnt=%b sticky=%b, required 00000001 0001",
                     probe_cnt, probe_sticky);
        end
        tick(3);
    endtask

    task automatic test_reset_mid();
        set_ch(3, 8'h77);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        zero_model();
        check_all_zero("reset_mid_state");
        for (int c = 0; c < NUM_CH; c++) begin
            push_event(c, probe_in[c*DATA_W +: DATA_W], cyc + LAT);
        end
        tick(LAT - 1);
        checks++;
        if (probe_out !== '0) begin
            errors++;
            $display("FAIL reset_mid_early got %h, required 0", probe_out);
        end
        tick(1);
        checks++;
        if (probe_out !== 32'h7703_053C) begin
            errors++;
            $display("FAIL reset_mid_deliver got %h, required 7703053c", probe_out);
        end
        tick(3);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_counter();
        test_freeze();
        test_clear_coincident();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
